// File: rtl/param_sub_seq_pkg.sv
// Shared definitions for the sequential chunked subtractor (param_sub_seq).
// Optional feature macro: PARAM_SUB_ZERO_FLAG_EN (adds a zero-result flag).
package param_sub_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the width splits into a whole number of non-empty chunks.
    function automatic bit width_chunk_ok(input int width, input int chunk);
        if (chunk < 1) begin
            return 1'b0;
        end
        return (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/param_sub_seq_if.sv
// Operand/result handshake bundle for param_sub_seq.
// zero_out exists only when PARAM_SUB_ZERO_FLAG_EN is defined.
interface param_sub_seq_if
    import param_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] a_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b_out;
    logic             borrow_out;
`ifdef PARAM_SUB_ZERO_FLAG_EN
    logic             zero_out;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, c_in, a_in, out_ready,
        input  in_ready, out_valid, b_out, borrow_out
`ifdef PARAM_SUB_ZERO_FLAG_EN
        , input zero_out
`endif
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, c_in, a_in, out_ready,
        output in_ready, out_valid, b_out, borrow_out
`ifdef PARAM_SUB_ZERO_FLAG_EN
        , output zero_out
`endif
    );

endinterface

// File: rtl/param_sub_seq_chunk.sv
// One CHUNK-bit slice of the subtractor: d = c - a - borrow_in, with the
// borrow taken from the extra MSB of a CHUNK+1-bit difference.
// With PARAM_SUB_ZERO_FLAG_EN defined, also reports whether the slice is zero.
module param_sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] c_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic             borrow_i,
    output logic [CHUNK-1:0] d_o,
    output logic             borrow_o
`ifdef PARAM_SUB_ZERO_FLAG_EN
    , output logic           zero_o
`endif
);

    logic [CHUNK:0] diff;

    // Zero-extended subtract: a negative result sets the top bit, which is the borrow.
    assign diff     = {1'b0, c_i} - {1'b0, a_i} - {{CHUNK{1'b0}}, borrow_i};
    assign d_o      = diff[CHUNK-1:0];
    assign borrow_o = diff[CHUNK];

`ifdef PARAM_SUB_ZERO_FLAG_EN
    assign zero_o   = (diff[CHUNK-1:0] == '0);
`endif

endmodule

// File: rtl/param_sub_seq.sv
// Sequential inverse of the WIDTH-bit adder: b_out = c_in - a_in (mod 2^WIDTH),
// processed CHUNK bits per cycle LSB first, behind valid/ready handshakes.
// Optional feature macro: PARAM_SUB_ZERO_FLAG_EN (zero_out, accumulated per chunk).
module param_sub_seq
    import param_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic           clk,
    input  logic           rst_n,
    param_sub_seq_if.slave bus
);

    localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (!width_chunk_ok(WIDTH, CHUNK)) begin : g_param_err
        $error("param_sub_seq: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   c_q;
    logic [WIDTH-1:0]   a_q;
    logic               borrow_q;
    logic [CHUNK-1:0]   b_chunk_q [NCHUNK];

    logic [CHUNK-1:0]   c_chunk   [NCHUNK];
    logic [CHUNK-1:0]   a_chunk   [NCHUNK];
    logic [WIDTH-1:0]   b_flat;
    logic [CHUNK-1:0]   diff_chunk;
    logic               borrow_d;
    logic               accept;
    logic               calc_step;

`ifdef PARAM_SUB_ZERO_FLAG_EN
    logic               zero_acc_q;
    logic               chunk_zero;
`endif

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign calc_step = (state_q == CALC);

    // Split the latched operands into chunks and reassemble the result chunks.
    always_comb begin
        b_flat = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            c_chunk[i] = c_q[i*CHUNK +: CHUNK];
            a_chunk[i] = a_q[i*CHUNK +: CHUNK];
            b_flat[i*CHUNK +: CHUNK] = b_chunk_q[i];
        end
    end

    // Single slice subtractor, fed the chunk selected by the counter each CALC cycle.
    param_sub_chunk #(
        .CHUNK    (CHUNK)
    ) u_chunk (
        .c_i      (c_chunk[cnt_q]),
        .a_i      (a_chunk[cnt_q]),
        .borrow_i (borrow_q),
        .d_o      (diff_chunk),
        .borrow_o (borrow_d)
`ifdef PARAM_SUB_ZERO_FLAG_EN
        , .zero_o (chunk_zero)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, walk NCHUNK chunks, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)       state_d = CALC;
            CALC:    if (cnt_q == LAST_CNT)  state_d = DONE;
            DONE:    if (bus.out_ready)      state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Operand capture, chunk counter and the borrow carried between chunks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q      <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            c_q      <= bus.c_in;
            a_q      <= bus.a_in;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else if (calc_step) begin
            cnt_q    <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
            borrow_q <= borrow_d;
        end
    end

    // Result chunks: each slot is written only in the CALC cycle that owns it,
    // so the previous result stays visible until it is overwritten.
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_res
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                b_chunk_q[gi] <= '0;
            end else if (calc_step && (cnt_q == CNT_W'(gi))) begin
                b_chunk_q[gi] <= diff_chunk;
            end
        end
    end

`ifdef PARAM_SUB_ZERO_FLAG_EN
    // Running AND of per-chunk zero tests; complete when out_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc_q <= 1'b0;
        end else if (accept) begin
            zero_acc_q <= 1'b1;
        end else if (calc_step) begin
            zero_acc_q <= zero_acc_q & chunk_zero;
        end
    end

    assign bus.zero_out = zero_acc_q;
`endif

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.b_out      = b_flat;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_param_sub_seq.sv
// Self-checking bench for param_sub_seq: three instances (32/8, 16/4, 16/16),
// directed cases plus random operands against an arithmetic reference model.
module tb_param_sub_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    param_sub_seq_if #(.WIDTH(32)) if32  ();
    param_sub_seq_if #(.WIDTH(16)) if16a ();
    param_sub_seq_if #(.WIDTH(16)) if16b ();

    param_sub_seq #(.WIDTH(32), .CHUNK(8))  u_dut32  (.clk(clk), .rst_n(rst_n), .bus(if32));
    param_sub_seq #(.WIDTH(16), .CHUNK(4))  u_dut16a (.clk(clk), .rst_n(rst_n), .bus(if16a));
    param_sub_seq #(.WIDTH(16), .CHUNK(16)) u_dut16b (.clk(clk), .rst_n(rst_n), .bus(if16b));

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- per-instance access helpers (sel: 0=32/8, 1=16/4, 2=16/16) ----
    function automatic int nchunk_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mask_of(input int sel);
        return (sel == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [31:0] c, input logic [31:0] a);
        case (sel)
            0:       begin if32.in_valid  = v; if32.c_in  = c;       if32.a_in  = a;       end
            1:       begin if16a.in_valid = v; if16a.c_in = c[15:0]; if16a.a_in = a[15:0]; end
            default: begin if16b.in_valid = v; if16b.c_in = c[15:0]; if16b.a_in = a[15:0]; end
        endcase
    endtask

    task automatic set_ready(input int sel, input logic r);
        case (sel)
            0:       if32.out_ready  = r;
            1:       if16a.out_ready = r;
            default: if16b.out_ready = r;
        endcase
    endtask

    function automatic logic [31:0] get_b(input int sel);
        case (sel)
            0:       return if32.b_out;
            1:       return 32'(if16a.b_out);
            default: return 32'(if16b.b_out);
        endcase
    endfunction

    function automatic logic get_valid(input int sel);
        case (sel)
            0:       return if32.out_valid;
            1:       return if16a.out_valid;
            default: return if16b.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return if32.in_ready;
            1:       return if16a.in_ready;
            default: return if16b.in_ready;
        endcase
    endfunction

    function automatic logic get_borrow(input int sel);
        case (sel)
            0:       return if32.borrow_out;
            1:       return if16a.borrow_out;
            default: return if16b.borrow_out;
        endcase
    endfunction

`ifdef PARAM_SUB_ZERO_FLAG_EN
    function automatic logic get_zero(input int sel);
        case (sel)
            0:       return if32.zero_out;
            1:       return if16a.zero_out;
            default: return if16b.zero_out;
        endcase
    endfunction
`endif

    // One full transaction: present operands, time the result, compare against
    // plain modular arithmetic, optionally stall the consumer for 'hold' cycles.
    task automatic run_op(input int sel, input logic [31:0] c, input logic [31:0] a, input int hold);
        logic [31:0] m;
        logic [31:0] exp_b;
        logic        exp_borrow;
        logic [31:0] held_b;
        int          n;
        m          = mask_of(sel);
        exp_b      = (c - a) & m;
        exp_borrow = ((c & m) < (a & m));

        @(negedge clk);
        check("in_ready_before", 32'(get_ready(sel)), 32'd1);
        drive_in(sel, 1'b1, c, a);
        set_ready(sel, hold == 0);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        drive_in(sel, 1'b0, $urandom, $urandom);
        while (!get_valid(sel) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", 32'(n), 32'(nchunk_of(sel) + 1));
        check("b_out", get_b(sel), exp_b);
        check("borrow_out", 32'(get_borrow(sel)), 32'(exp_borrow));
`ifdef PARAM_SUB_ZERO_FLAG_EN
        check("zero_out", 32'(get_zero(sel)), 32'(exp_b == 32'd0));
`endif
        $display("txn dut=%0d c=%h a=%h b=%h borrow=%0d lat=%0d hold=%0d",
                 sel, c & m, a & m, get_b(sel), get_borrow(sel), n, hold);

        held_b = exp_b;
        for (int k = 0; k < hold; k++) begin
            drive_in(sel, 1'b1, $urandom, $urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(get_valid(sel)), 32'd1);
            check("hold_in_ready", 32'(get_ready(sel)), 32'd0);
            check("hold_b_out", get_b(sel), held_b);
        end
        drive_in(sel, 1'b0, 32'd0, 32'd0);
        set_ready(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("post_valid", 32'(get_valid(sel)), 32'd0);
        check("post_in_ready", 32'(get_ready(sel)), 32'd1);
        check("post_b_retained", get_b(sel), exp_b);
    endtask

    initial begin
        logic [31:0] rc;
        logic [31:0] ra;
        for (int s = 0; s < 3; s++) begin
            drive_in(s, 1'b0, 32'd0, 32'd0);
            set_ready(s, 1'b0);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(if32.out_valid), 32'd0);
        check("rst_in_ready", 32'(if32.in_ready), 32'd1);
        check("rst_b_out", if32.b_out, 32'd0);
        check("rst_borrow", 32'(if32.borrow_out), 32'd0);
`ifdef PARAM_SUB_ZERO_FLAG_EN
        check("rst_zero", 32'(if32.zero_out), 32'd0);
`endif
        rst_n = 1'b1;

        // Directed cases on the 32/8 instance.
        run_op(0, 32'h0000_0013, 32'h0000_0001, 0);
        run_op(0, 32'h0000_0100, 32'h0000_0001, 0);
        run_op(0, 32'h0000_0000, 32'h0000_0001, 0);
        run_op(0, 32'h1234_5678, 32'h1234_5678, 0);
        run_op(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);

        // Asynchronous reset during the second CALC cycle.
        @(negedge clk);
        drive_in(0, 1'b1, 32'hABCD_1234, 32'h0000_0001);
        @(posedge clk);
        @(negedge clk);
        drive_in(0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(if32.out_valid), 32'd0);
        check("midrst_in_ready", 32'(if32.in_ready), 32'd1);
        check("midrst_b_out", if32.b_out, 32'd0);
        check("midrst_borrow", 32'(if32.borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 32'h0000_0013, 32'h0000_0001, 0);

        // Other geometries, including a single-chunk instance.
        run_op(1, 32'h0000_0013, 32'h0000_0001, 0);
        run_op(2, 32'h0000_0013, 32'h0000_0001, 0);
        run_op(1, 32'h0000_0000, 32'h0000_FFFF, 1);
        run_op(2, 32'h0000_8000, 32'h0000_8001, 2);

        // Random operands, occasionally equal, with random consumer stalls.
        for (int i = 0; i < 36; i++) begin
            rc = $urandom;
            ra = ($urandom_range(0, 4) == 0) ? rc : $urandom;
            run_op(i % 3, rc, ra, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
